// File: rtl/mlp_2_3_2_backprop.sv
// 2-input, 3-hidden, 2-output sigmoid perceptron in Q8.24 with a 4-stage
// forward pipeline and a single-cycle backpropagation step on `update`.
module mlp_2_3_2_backprop #(
  parameter int W    = 32,
  parameter int FRAC = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] t1,
  input  logic signed [W-1:0] t2,
  input  logic signed [W-1:0] step,
  input  logic                update,
  input  logic                load_en,
  input  logic        [4:0]   load_addr,
  input  logic signed [W-1:0] load_data,
  output logic signed [W-1:0] h1,
  output logic signed [W-1:0] h2,
  output logic signed [W-1:0] h3,
  output logic signed [W-1:0] y1,
  output logic signed [W-1:0] y2,
  output logic                ready
);

  localparam logic signed [W-1:0] ONE     = W'(1) << FRAC;
  localparam logic signed [W-1:0] SIG_A2  = W'(5) << FRAC;         // 5.0
  localparam logic signed [W-1:0] SIG_A1  = W'(19) << (FRAC - 3);  // 2.375
  localparam logic signed [W-1:0] SIG_C2  = W'(27) << (FRAC - 5);  // 0.84375
  localparam logic signed [W-1:0] SIG_C1  = W'(5) << (FRAC - 3);   // 0.625
  localparam logic signed [W-1:0] SIG_MID = W'(1) << (FRAC - 1);   // 0.5

  function automatic logic signed [W-1:0] fmul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] be;
    logic signed [2*W-1:0] p;
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
    p  = (ae * be) >>> FRAC;
    return p[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sig(input logic signed [W-1:0] z);
    logic signed [W-1:0] a;
    logic signed [W-1:0] f;
    a = z[W-1] ? -z : z;
    if (a >= SIG_A2)      f = ONE;
    else if (a >= SIG_A1) f = (a >>> 5) + SIG_C2;
    else if (a >= ONE)    f = (a >>> 3) + SIG_C1;
    else                  f = (a >>> 2) + SIG_MID;
    return z[W-1] ? ONE - f : f;
  endfunction

  logic signed [W-1:0] wh_reg [3][2];
  logic signed [W-1:0] wo_reg [2][3];
  logic signed [W-1:0] bh_reg [3];
  logic signed [W-1:0] bo_reg [2];

  logic signed [W-1:0] zh_reg [3];
  logic signed [W-1:0] h_reg  [3];
  logic signed [W-1:0] zo_reg [2];
  logic signed [W-1:0] y_reg  [2];
  logic        [2:0]   settle_reg;

  logic signed [W-1:0] x_vec    [2];
  logic signed [W-1:0] t_vec    [2];
  logic signed [W-1:0] zh_next  [3];
  logic signed [W-1:0] zo_next  [2];
  logic signed [W-1:0] do_val   [2];
  logic signed [W-1:0] go_val   [2];
  logic signed [W-1:0] back_sum [3];
  logic signed [W-1:0] dh_val   [3];
  logic signed [W-1:0] gh_val   [3];
  logic                train;

  assign x_vec[0] = x1;
  assign x_vec[1] = x2;
  assign t_vec[0] = t1;
  assign t_vec[1] = t2;

  assign ready = (settle_reg == 3'd4);
  // A load on the same edge takes priority and drops the training step.
  assign train = update && ready && !load_en;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hidden
      assign zh_next[gi]  = bh_reg[gi] + fmul(wh_reg[gi][0], x_vec[0])
                                       + fmul(wh_reg[gi][1], x_vec[1]);
      assign back_sum[gi] = fmul(wo_reg[0][gi], do_val[0]) + fmul(wo_reg[1][gi], do_val[1]);
      assign dh_val[gi]   = fmul(fmul(h_reg[gi], ONE - h_reg[gi]), back_sum[gi]);
      assign gh_val[gi]   = fmul(step, dh_val[gi]);
    end
    for (gi = 0; gi < 2; gi++) begin : g_output
      assign zo_next[gi] = bo_reg[gi] + fmul(wo_reg[gi][0], h_reg[0])
                                      + fmul(wo_reg[gi][1], h_reg[1])
                                      + fmul(wo_reg[gi][2], h_reg[2]);
      assign do_val[gi]  = fmul(fmul(t_vec[gi] - y_reg[gi], y_reg[gi]), ONE - y_reg[gi]);
      assign go_val[gi]  = fmul(step, do_val[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 3; j++) begin
        bh_reg[j] <= '0;
        for (int i = 0; i < 2; i++) wh_reg[j][i] <= '0;
      end
      for (int k = 0; k < 2; k++) begin
        bo_reg[k] <= '0;
        for (int j = 0; j < 3; j++) wo_reg[k][j] <= '0;
      end
    end else if (load_en) begin
      for (int j = 0; j < 3; j++) begin
        if (load_addr == 5'(12 + j)) bh_reg[j] <= load_data;
        for (int i = 0; i < 2; i++)
          if (load_addr == 5'(2 * j + i)) wh_reg[j][i] <= load_data;
      end
      for (int k = 0; k < 2; k++) begin
        if (load_addr == 5'(15 + k)) bo_reg[k] <= load_data;
        for (int j = 0; j < 3; j++)
          if (load_addr == 5'(6 + 3 * k + j)) wo_reg[k][j] <= load_data;
      end
    end else if (train) begin
      // All deltas come from the registered h/y and the pre-update weights.
      for (int j = 0; j < 3; j++) begin
        bh_reg[j] <= bh_reg[j] + gh_val[j];
        for (int i = 0; i < 2; i++)
          wh_reg[j][i] <= wh_reg[j][i] + fmul(gh_val[j], x_vec[i]);
      end
      for (int k = 0; k < 2; k++) begin
        bo_reg[k] <= bo_reg[k] + go_val[k];
        for (int j = 0; j < 3; j++)
          wo_reg[k][j] <= wo_reg[k][j] + fmul(go_val[k], h_reg[j]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 3; j++) begin
        zh_reg[j] <= '0;
        h_reg[j]  <= SIG_MID;
      end
      for (int k = 0; k < 2; k++) begin
        zo_reg[k] <= '0;
        y_reg[k]  <= SIG_MID;
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        zh_reg[j] <= zh_next[j];
        h_reg[j]  <= sig(zh_reg[j]);
      end
      for (int k = 0; k < 2; k++) begin
        zo_reg[k] <= zo_next[k];
        y_reg[k]  <= sig(zo_reg[k]);
      end
    end
  end

  // Counts pipeline depth after any coefficient change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  settle_reg <= 3'd0;
    else if (load_en || train)  settle_reg <= 3'd0;
    else if (settle_reg != 3'd4) settle_reg <= settle_reg + 3'd1;
  end

  assign h1 = h_reg[0];
  assign h2 = h_reg[1];
  assign h3 = h_reg[2];
  assign y1 = y_reg[0];
  assign y2 = y_reg[1];

endmodule

// File: tb/tb_mlp_2_3_2_backprop.sv
// Scoreboard bench for mlp_2_3_2_backprop: a flat-coefficient fixed-point
// model produces expected h/y; a monitor compares whenever ready is high.
`timescale 1ns/1ps
module tb_mlp_2_3_2_backprop;

  localparam int ONE = 32'h01000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] x1, x2, t1, t2, step, load_data;
  logic        update, load_en;
  logic [4:0]  load_addr;
  logic [31:0] h1, h2, h3, y1, y2;
  logic        ready;

  mlp_2_3_2_backprop dut (
    .clk(clk), .reset(reset), .x1(x1), .x2(x2), .t1(t1), .t2(t2), .step(step),
    .update(update), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .h1(h1), .h2(h2), .h3(h3), .y1(y1), .y2(y2), .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: coefficients stored flat by load address.
  int m_c [17];
  int m_x [2];
  int m_t [2];
  int m_step;
  int m_h [3];
  int m_y [2];

  function automatic int fx_mul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 24);
  endfunction

  function automatic int fx_sig(int z);
    int a, f;
    a = (z < 0) ? -z : z;
    if (a >= 5 * ONE)              f = ONE;
    else if (a >= (19 * ONE) / 8)  f = (a >>> 5) + (27 * ONE) / 32;
    else if (a >= ONE)             f = (a >>> 3) + (5 * ONE) / 8;
    else                           f = (a >>> 2) + ONE / 2;
    return (z < 0) ? ONE - f : f;
  endfunction

  function automatic void model_forward();
    int z;
    for (int j = 0; j < 3; j++)
      m_h[j] = fx_sig(m_c[12 + j] + fx_mul(m_c[2 * j], m_x[0]) + fx_mul(m_c[2 * j + 1], m_x[1]));
    for (int k = 0; k < 2; k++) begin
      z = m_c[15 + k];
      for (int j = 0; j < 3; j++) z += fx_mul(m_c[6 + 3 * k + j], m_h[j]);
      m_y[k] = fx_sig(z);
    end
  endfunction

  function automatic void model_train();
    int d_o [2];
    int d_h [3];
    int nc  [17];
    model_forward();
    for (int k = 0; k < 2; k++)
      d_o[k] = fx_mul(fx_mul(m_t[k] - m_y[k], m_y[k]), ONE - m_y[k]);
    for (int j = 0; j < 3; j++)
      d_h[j] = fx_mul(fx_mul(m_h[j], ONE - m_h[j]),
                      fx_mul(m_c[6 + j], d_o[0]) + fx_mul(m_c[9 + j], d_o[1]));
    nc = m_c;
    for (int k = 0; k < 2; k++) begin
      nc[15 + k] += fx_mul(m_step, d_o[k]);
      for (int j = 0; j < 3; j++) nc[6 + 3 * k + j] += fx_mul(fx_mul(m_step, d_o[k]), m_h[j]);
    end
    for (int j = 0; j < 3; j++) begin
      nc[12 + j] += fx_mul(m_step, d_h[j]);
      for (int i = 0; i < 2; i++) nc[2 * j + i] += fx_mul(fx_mul(m_step, d_h[j]), m_x[i]);
    end
    m_c = nc;
  endfunction

  // Scoreboard
  typedef struct {
    logic [31:0] h1, h2, h3, y1, y2;
    bit          conv;
    int          min_cyc;
  } exp_t;

  exp_t  sb [$];
  string sb_name [$];
  int    checks = 0;
  int    errors = 0;

  function automatic void check_eq(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %08h want %08h", name, act, want);
    end
  endfunction

  function automatic void check_true(string name, bit ok, logic [31:0] act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %08h", name, act);
    end
  endfunction

  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (!reset && ready === 1'b1 && sb.size() > 0) begin
      if (cyc >= sb[0].min_cyc) begin
        mon_e = sb.pop_front();
        mon_n = sb_name.pop_front();
        if (mon_e.conv) begin
          check_true({mon_n, ".y1>0.9"}, $signed(y1) > 32'sh00E66666, y1);
          check_true({mon_n, ".y2<0.1"}, $signed(y2) < 32'sh0019999A, y2);
        end else begin
          check_eq({mon_n, ".h1"}, h1, mon_e.h1);
          check_eq({mon_n, ".h2"}, h2, mon_e.h2);
          check_eq({mon_n, ".h3"}, h3, mon_e.h3);
          check_eq({mon_n, ".y1"}, y1, mon_e.y1);
          check_eq({mon_n, ".y2"}, y2, mon_e.y2);
        end
        $display("TXN %-14s h=%08h %08h %08h y=%08h %08h", mon_n, h1, h2, h3, y1, y2);
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] eh1, input logic [31:0] eh2,
                          input logic [31:0] eh3, input logic [31:0] ey1,
                          input logic [31:0] ey2, input bit conv);
    exp_t e;
    e.h1 = eh1; e.h2 = eh2; e.h3 = eh3; e.y1 = ey1; e.y2 = ey2;
    e.conv = conv;
    e.min_cyc = cyc + 5;
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for ready", sb_name[0]);
      sb.delete();
      sb_name.delete();
    end
  endtask

  task automatic expect_model(input string name);
    model_forward();
    push_exp(name, m_h[0], m_h[1], m_h[2], m_y[0], m_y[1], 1'b0);
    drain();
  endtask

  task automatic set_inputs();
    x1 = m_x[0]; x2 = m_x[1];
    t1 = m_t[0]; t2 = m_t[1];
    step = m_step;
  endtask

  task automatic do_load(input int addr, input int data);
    load_en = 1'b1;
    load_addr = addr[4:0];
    load_data = data;
    if (addr < 17) m_c[addr] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Caller guarantees ready is high at this negedge.
  task automatic do_update();
    update = 1'b1;
    model_train();
    @(negedge clk);
    update = 1'b0;
  endtask

  function automatic int rnd_span(int lo, int span);
    return lo + int'($urandom_range(0, span));
  endfunction

  initial begin
    int w;
    int v;
    update = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    m_c = '{default: 0};
    m_x[0] = 32'h08000000; m_x[1] = 32'h05000000;
    m_t[0] = ONE; m_t[1] = 0;
    m_step = 32'h00199999;
    set_inputs();

    repeat (3) @(negedge clk);
    check_eq("rst.ready", 32'(ready), 32'd0);
    check_eq("rst.h1", h1, 32'h00800000);
    check_eq("rst.y2", y2, 32'h00800000);
    reset = 1'b0;

    push_exp("settle", 32'h00800000, 32'h00800000, 32'h00800000,
             32'h00800000, 32'h00800000, 1'b0);
    drain();

    // First step from zero coefficients; values worked out by hand.
    do_update();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drop%0d.ready", i), 32'(ready), 32'd0);
      @(negedge clk);
    end
    check_eq("drop.ready_back", 32'(ready), 32'd1);
    push_exp("first_step", 32'h00800000, 32'h00800000, 32'h00800000,
             32'h00816665, 32'h007E999A, 1'b0);
    drain();
    model_forward();

    for (int a = 0; a < 17; a++) do_load(a, (a == 0) ? ONE : 0);
    m_x[0] = 32'h00800000; m_x[1] = 0;
    set_inputs();
    model_forward();
    push_exp("h_half", 32'h00A00000, m_h[1], m_h[2], m_y[0], m_y[1], 1'b0);
    drain();
    m_x[0] = 32'hFA000000;
    set_inputs();
    model_forward();
    push_exp("h_neg6", 32'h00000000, m_h[1], m_h[2], m_y[0], m_y[1], 1'b0);
    drain();

    do_load(15, 32'h00400000);
    update = 1'b1;
    repeat (3) @(negedge clk);
    update = 1'b0;
    expect_model("upd_not_ready");

    load_en = 1'b1; load_addr = 5'd16; load_data = 32'hFFC00000; update = 1'b1;
    m_c[16] = 32'hFFC00000;
    @(negedge clk);
    load_en = 1'b0; update = 1'b0;
    expect_model("collide");

    do_load(17, 32'h7FFFFFFF);
    do_load(20, 32'h01000000);
    do_load(31, 32'h02000000);
    expect_model("ignored_addr");

    for (int it = 0; it < 12; it++) begin
      for (int n = 0; n < 3; n++)
        do_load(int'($urandom_range(0, 16)), rnd_span(-32'sh02000000, 32'h03FFFFFF));
      m_x[0] = rnd_span(-32'sh08000000, 32'h0FFFFFFF);
      m_x[1] = rnd_span(-32'sh08000000, 32'h0FFFFFFF);
      m_t[0] = int'($urandom_range(0, ONE));
      m_t[1] = int'($urandom_range(0, ONE));
      m_step = int'($urandom_range(0, 32'h00400000));
      set_inputs();
      expect_model($sformatf("rnd%0d.fwd", it));
      do_update();
      expect_model($sformatf("rnd%0d.trn", it));
    end

    // Reset asserted on the same edge as an accepted update.
    m_x[0] = 32'h08000000; m_x[1] = 32'h05000000;
    m_t[0] = ONE; m_t[1] = 0;
    m_step = 32'h00199999;
    set_inputs();
    update = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    update = 1'b0;
    m_c = '{default: 0};
    expect_model("mid_reset");

    for (int a = 0; a < 17; a++) begin
      v = rnd_span(-32'sh00400000, 32'h007FFFFF);
      do_load(a, (v == 0) ? 1 : v);
    end
    expect_model("conv.init");
    for (int n = 1; n <= 10000; n++) begin
      w = 0;
      while (ready !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL conv.ready timeout at update %0d", n);
        break;
      end
      do_update();
      if (n % 2500 == 0) expect_model($sformatf("conv%0d", n));
    end
    model_forward();
    push_exp("conv.final", m_h[0], m_h[1], m_h[2], m_y[0], m_y[1], 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mlp_2_3_2_backprop.md
Name: mlp_2_3_2_backprop

Overview:
- Fixed-point 2-input, 3-hidden, 2-output sigmoid perceptron with on-chip single-sample backpropagation training.
- Forward pass is continuously pipelined. An `update` strobe applies one gradient-descent step to all 12 weights and 5 biases.
- Sits under the training controller, which loads initial coefficients, drives sample and target, waits for `ready`, then pulses `update`.

Parameters:
- W, 32, data width; all values signed two's complement fixed point.
- FRAC, 24, fraction bits (Q8.24); the constant ONE = 1<<FRAC = 0x01000000.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- x1, x2  in  W  sample inputs (Q8.24)
- t1, t2  in  W  training targets (Q8.24)
- step  in  W  learning rate (Q8.24), e.g. 0x00199999 ≈ 0.1
- update  in  1  apply one training step on this clock edge
- load_en  in  1  write a coefficient
- load_addr  in  5  coefficient index for load
- load_data  in  W  coefficient value for load
- h1, h2, h3  out  W  hidden activations (registered)
- y1, y2  out  W  output activations (registered)
- ready  out  1  forward pipeline settled for the current coefficients

Behaviour:
- Reset:
  - All weights and biases = 0.
  - All pipeline registers = 0 except activation registers, which = 0x00800000 (sigmoid(0)).
  - Settle counter = 0, so `ready` = 0.
- Load address map:
  - 0..5: hidden weights wh[j][i], index 2j+i (j = 0..2, i = 0..1).
  - 6..11: output weights wo[k][j], index 6+3k+j (k = 0..1).
  - 12..14: hidden biases bh[j].
  - 15..16: output biases bo[k].
  - 17..31: write ignored.
- Multiply: full 64-bit signed product, arithmetic shift right by FRAC, keep low 32 bits. Add/subtract wrap modulo 2^32.
- Sigmoid, piecewise-linear, with a = |z|:
  - f = 1.0 for a ≥ 5.0
  - f = a/32 + 0.84375 for 2.375 ≤ a < 5
  - f = a/8 + 0.625 for 1 ≤ a < 2.375
  - f = a/4 + 0.5 for a < 1
  - For z < 0 the result is 1.0 − f(a). Shifts are arithmetic.
- Forward pipeline, one register per stage:
  - S1: zh[j] = bh[j] + wh[j][0]·x1 + wh[j][1]·x2
  - S2: h[j] = sig(zh[j])
  - S3: zo[k] = bo[k] + Σj wo[k][j]·h[j]
  - S4: y[k] = sig(zo[k])
  - Latency: 4 cycles from an input or coefficient change to y.
- Settle counter:
  - Cleared on reset, on any cycle with load_en, and on any accepted update.
  - Otherwise increments each cycle, saturating at 4.
  - ready = (count == 4).
  - Changing x/t without waiting is the controller's responsibility; `ready` does not track x/t.
- Training, on a clock edge with update=1 and ready=1; all values use the registered h, y and old coefficients:
  - do[k] = (t[k] − y[k])·y[k]·(ONE − y[k])
  - dh[j] = h[j]·(ONE − h[j])·(wo[0][j]·do[0] + wo[1][j]·do[1])
  - wo[k][j] += step·do[k]·h[j]
  - bo[k] += step·do[k]
  - wh[j][i] += step·dh[j]·x[i]
  - bh[j] += step·dh[j]
  - All 17 coefficients update simultaneously in one cycle.
- Products are evaluated left to right, with truncation after each multiply.
- update=1 while ready=0: ignored, no coefficient change.
- load_en and update in the same cycle: load wins and update is dropped.
- Reset mid-update: coefficients return to 0 immediately.

Test Plan:
- Reset, then x=(8.0,5.0) (0x08000000, 0x05000000), wait until ready → h1..h3 = y1 = y2 = 0x00800000.
- Zero coefficients, t=(ONE,0), step=0x00199999, one update:
  - bo[0] ≈ +0.0125 (0x00033333 ±2 LSB), bo[1] ≈ −0.0125.
  - wo[k][j] ≈ ±0.00625.
  - All hidden coefficients remain 0, because old wo = 0.
  - ready drops for 4 cycles.
- Load wh[0][0]=ONE, all else 0, x1=0.5 → zh0=0.5, h1 = 0x00A00000 (0.625); x1=−6.0 → h1=0.
- Pulse update while ready=0, immediately after a load → all coefficients unchanged.
- Load-and-update collision on the same edge → loaded value stored; no training step.
- Convergence: x=(8,5), t=(1,0), step≈0.1, 10000 update cycles from a nonzero random init → y1 > 0.9, y2 < 0.1.
